// File: rtl/common_pkg.sv
// Types shared across pipeline stages: raw instruction word, decoded control
// word and the hard-wired zero register index.
package common_pkg;

    typedef logic [31:0] instruction_type;

    typedef struct packed {
        logic [3:0] alu_op;
        logic       alu_src;
        logic       mem_read;
        logic       mem_write;
        logic       reg_write;
        logic       branch;
        logic       jump;
    } control_type;

    localparam logic [4:0] REG_ZERO = 5'd0;

endpackage

// File: rtl/decode_execute_buffer_pkg.sv
// Payload type for one buffered decode->execute entry plus the write-back
// hit test used by the operand patch logic.
package decode_execute_buffer_pkg;
    import common_pkg::*;

    localparam int ID_EX_DATA_W = 32;

    typedef struct packed {
        logic [ID_EX_DATA_W-1:0] pc;
        instruction_type         instruction;
        logic                    compflg;
        logic [4:0]              rs1_id;
        logic [4:0]              rs2_id;
        logic [4:0]              rd_id;
        logic [ID_EX_DATA_W-1:0] read_data1;
        logic [ID_EX_DATA_W-1:0] read_data2;
        logic [ID_EX_DATA_W-1:0] immediate;
        control_type             control;
    } id_ex_entry_t;

    // Writes to x0 are architecturally discarded, so they never refresh operands.
    function automatic logic wbHit(input logic en, input logic [4:0] wid, input logic [4:0] rid);
        return en && (wid != REG_ZERO) && (wid == rid);
    endfunction

endpackage

// File: rtl/decode_execute_buffer_if.sv
// Decode->execute handshake bundle including the write-back snoop and squash.
// master = surrounding pipeline, slave = the buffer.
interface decode_execute_buffer_if
    import common_pkg::*;
#(
    parameter int DATA_W = 32
);
    logic              in_valid;
    logic              in_ready;
    logic [DATA_W-1:0] in_pc;
    instruction_type   in_instruction;
    logic              in_compflg;
    logic [4:0]        in_rs1_id;
    logic [4:0]        in_rs2_id;
    logic [4:0]        in_rd_id;
    logic [DATA_W-1:0] in_read_data1;
    logic [DATA_W-1:0] in_read_data2;
    logic [DATA_W-1:0] in_immediate;
    control_type       in_control;

    logic              wb_write_en;
    logic [4:0]        wb_write_id;
    logic [DATA_W-1:0] wb_write_data;
    logic              squash;

    logic              out_valid;
    logic              out_ready;
    logic [DATA_W-1:0] out_pc;
    instruction_type   out_instruction;
    logic              out_compflg;
    logic [4:0]        out_rs1_id;
    logic [4:0]        out_rs2_id;
    logic [4:0]        out_rd_id;
    logic [DATA_W-1:0] out_read_data1;
    logic [DATA_W-1:0] out_read_data2;
    logic [DATA_W-1:0] out_immediate;
    control_type       out_control;

    modport master (
        output in_valid, in_pc, in_instruction, in_compflg, in_rs1_id, in_rs2_id, in_rd_id,
               in_read_data1, in_read_data2, in_immediate, in_control,
               wb_write_en, wb_write_id, wb_write_data, squash, out_ready,
        input  in_ready, out_valid, out_pc, out_instruction, out_compflg, out_rs1_id,
               out_rs2_id, out_rd_id, out_read_data1, out_read_data2, out_immediate, out_control
    );

    modport slave (
        input  in_valid, in_pc, in_instruction, in_compflg, in_rs1_id, in_rs2_id, in_rd_id,
               in_read_data1, in_read_data2, in_immediate, in_control,
               wb_write_en, wb_write_id, wb_write_data, squash, out_ready,
        output in_ready, out_valid, out_pc, out_instruction, out_compflg, out_rs1_id,
               out_rs2_id, out_rd_id, out_read_data1, out_read_data2, out_immediate, out_control
    );

endinterface

// File: rtl/decode_execute_operand_patch.sv
// Combinational operand refresh: replaces rs1/rs2 operands of one entry with
// write-back data when the write-back targets that source register.
module decode_execute_operand_patch
    import decode_execute_buffer_pkg::*;
(
    input  id_ex_entry_t            entry_i,
    input  logic                    wbWriteEn_i,
    input  logic [4:0]              wbWriteId_i,
    input  logic [ID_EX_DATA_W-1:0] wbWriteData_i,
    output id_ex_entry_t            entry_o
);

    always_comb begin
        entry_o = entry_i;
        if (wbHit(wbWriteEn_i, wbWriteId_i, entry_i.rs1_id)) entry_o.read_data1 = wbWriteData_i;
        if (wbHit(wbWriteEn_i, wbWriteId_i, entry_i.rs2_id)) entry_o.read_data2 = wbWriteData_i;
    end

endmodule

// File: rtl/decode_execute_buffer.sv
// Elastic decode->execute buffer with write-back operand snooping and squash.
// Optional performance counters are enabled with `define ID_EX_PERF_CNT_EN.
module decode_execute_buffer
    import common_pkg::*;
    import decode_execute_buffer_pkg::*;
#(
    parameter int DEPTH       = 2,
    parameter int DATA_W      = 32,
    parameter int STALL_CNT_W = 32
)(
    input  logic                       clk,
    input  logic                       rst,
    decode_execute_buffer_if.slave     bus,
    output logic [STALL_CNT_W-1:0]     stall_cycles,
    output logic [15:0]                squash_count
);

    localparam int PTR_W = $clog2(DEPTH);
    localparam logic [PTR_W:0] FULL_COUNT = (PTR_W+1)'(DEPTH);

    logic [PTR_W-1:0] wrPtr_q, wrPtr_d, rdPtr_q, rdPtr_d;
    logic [PTR_W:0]   count_q, count_d;
    id_ex_entry_t     entry_q [DEPTH];
    id_ex_entry_t     entry_d [DEPTH];
    id_ex_entry_t     patched [DEPTH];
    id_ex_entry_t     inEntry, inPatched, head;
    logic [DEPTH-1:0] entryValid;
    logic             push, pop;

    assign bus.in_ready  = (count_q != FULL_COUNT);
    assign bus.out_valid = (count_q != '0);
    assign push = bus.in_valid && bus.in_ready;
    assign pop  = bus.out_valid && bus.out_ready;

    assign inEntry = '{pc: bus.in_pc, instruction: bus.in_instruction, compflg: bus.in_compflg,
                       rs1_id: bus.in_rs1_id, rs2_id: bus.in_rs2_id, rd_id: bus.in_rd_id,
                       read_data1: bus.in_read_data1, read_data2: bus.in_read_data2,
                       immediate: bus.in_immediate, control: bus.in_control};

    decode_execute_operand_patch u_pushPatch (
        .entry_i       (inEntry),
        .wbWriteEn_i   (bus.wb_write_en),
        .wbWriteId_i   (bus.wb_write_id),
        .wbWriteData_i (bus.wb_write_data),
        .entry_o       (inPatched)
    );

    for (genvar g = 0; g < DEPTH; g++) begin : g_patch
        decode_execute_operand_patch u_patch (
            .entry_i       (entry_q[g]),
            .wbWriteEn_i   (bus.wb_write_en),
            .wbWriteId_i   (bus.wb_write_id),
            .wbWriteData_i (bus.wb_write_data),
            .entry_o       (patched[g])
        );
    end

    // An entry is live when its distance from the read pointer is below the count.
    always_comb begin
        entryValid = '0;
        for (int i = 0; i < DEPTH; i++) begin
            logic [PTR_W-1:0] offset;
            offset = PTR_W'(i) - rdPtr_q;
            entryValid[i] = ({1'b0, offset} < count_q);
        end
    end

    always_comb begin
        wrPtr_d = wrPtr_q;
        rdPtr_d = rdPtr_q;
        count_d = count_q;
        for (int i = 0; i < DEPTH; i++) begin
            entry_d[i] = entry_q[i];
            // The departing head is forwarded by execute, so it keeps its old operands.
            if (entryValid[i] && !(pop && (PTR_W'(i) == rdPtr_q))) entry_d[i] = patched[i];
        end
        if (bus.squash) begin
            count_d = '0;
            rdPtr_d = wrPtr_q;
        end else begin
            if (push) begin
                entry_d[wrPtr_q] = inPatched;
                wrPtr_d = wrPtr_q + PTR_W'(1);
            end
            if (pop) rdPtr_d = rdPtr_q + PTR_W'(1);
            case ({push, pop})
                2'b10:   count_d = count_q + (PTR_W+1)'(1);
                2'b01:   count_d = count_q - (PTR_W+1)'(1);
                default: count_d = count_q;
            endcase
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wrPtr_q <= '0;
            rdPtr_q <= '0;
            count_q <= '0;
            for (int i = 0; i < DEPTH; i++) entry_q[i] <= '0;
        end else begin
            wrPtr_q <= wrPtr_d;
            rdPtr_q <= rdPtr_d;
            count_q <= count_d;
            for (int i = 0; i < DEPTH; i++) entry_q[i] <= entry_d[i];
        end
    end

    assign head = entry_q[rdPtr_q];
    assign bus.out_pc          = head.pc;
    assign bus.out_instruction = head.instruction;
    assign bus.out_compflg     = head.compflg;
    assign bus.out_rs1_id      = head.rs1_id;
    assign bus.out_rs2_id      = head.rs2_id;
    assign bus.out_rd_id       = head.rd_id;
    assign bus.out_read_data1  = head.read_data1;
    assign bus.out_read_data2  = head.read_data2;
    assign bus.out_immediate   = head.immediate;
    assign bus.out_control     = head.control;

`ifdef ID_EX_PERF_CNT_EN
    logic [STALL_CNT_W-1:0] stallCycles_q;
    logic [15:0]            squashCount_q;

    // Both counters saturate rather than wrap so long runs stay meaningful.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            stallCycles_q <= '0;
            squashCount_q <= '0;
        end else begin
            if (bus.out_valid && !bus.out_ready && (stallCycles_q != '1))
                stallCycles_q <= stallCycles_q + STALL_CNT_W'(1);
            if (bus.squash && (count_q != '0) && (squashCount_q != 16'hFFFF))
                squashCount_q <= squashCount_q + 16'd1;
        end
    end

    assign stall_cycles = stallCycles_q;
    assign squash_count = squashCount_q;
`else
    assign stall_cycles = '0;
    assign squash_count = '0;
`endif

endmodule

// File: tb/tb_decode_execute_buffer.sv
// Directed self-checking bench for decode_execute_buffer (DEPTH=2).
// Counter expectations follow whether ID_EX_PERF_CNT_EN is defined.
module tb_decode_execute_buffer;
   import common_pkg::*;

   logic clk;
   logic rst;
   int   compared;
   int   mismatched;

   logic [31:0] stallCycles;
   logic [15:0] squashCount;

   decode_execute_buffer_if #(.DATA_W(32)) bus ();

   decode_execute_buffer #(.DEPTH(2), .DATA_W(32), .STALL_CNT_W(32)) dut (
      .clk          (clk),
      .rst          (rst),
      .bus          (bus),
      .stall_cycles (stallCycles),
      .squash_count (squashCount)
   );

   // Free-running 10 ns clock
   initial clk = 1'b0;
   always #5 clk = ~clk;

   // Single comparison point: counts every check and reports any mismatch
   task automatic checkOutput(input string tag, input logic [63:0] observed, input logic [63:0] expected);
      compared++;
      if (observed !== expected) begin
         mismatched++;
         $display("[TB] FAIL %s: got %0h expected %0h", tag, observed, expected);
      end
   endtask

   // Drives one decode-side entry; non-operand fields derive from the PC
   task automatic applyStimulus(input logic valid, input logic [31:0] pc, input logic [4:0] rs1,
                                input logic [4:0] rs2, input logic [31:0] d1, input logic [31:0] d2);
      bus.in_valid       = valid;
      bus.in_pc          = pc;
      bus.in_instruction = pc ^ 32'h0000_0013;
      bus.in_compflg     = pc[1];
      bus.in_rs1_id      = rs1;
      bus.in_rs2_id      = rs2;
      bus.in_rd_id       = 5'd1;
      bus.in_read_data1  = d1;
      bus.in_read_data2  = d2;
      bus.in_immediate   = pc + 32'd4;
      bus.in_control     = '0;
   endtask

   task automatic applyWriteBack(input logic en, input logic [4:0] id, input logic [31:0] data);
      bus.wb_write_en   = en;
      bus.wb_write_id   = id;
      bus.wb_write_data = data;
   endtask

   // Advance one clock and settle 1 ns past the rising edge
   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   logic [31:0] expStall10;
   logic [15:0] expSquash1;

   initial begin
      compared   = 0;
      mismatched = 0;
`ifdef ID_EX_PERF_CNT_EN
      expStall10 = 32'd10;
      expSquash1 = 16'd1;
`else
      expStall10 = 32'd0;
      expSquash1 = 16'd0;
`endif
      rst = 1'b1;
      applyStimulus(1'b0, 32'h0, 5'd0, 5'd0, 32'h0, 32'h0);
      applyWriteBack(1'b0, 5'd0, 32'h0);
      bus.squash    = 1'b0;
      bus.out_ready = 1'b0;
      #12;
      checkOutput("reset_out_valid", {63'd0, bus.out_valid}, 64'd0);
      checkOutput("reset_in_ready", {63'd0, bus.in_ready}, 64'd1);
      checkOutput("reset_stall", {32'd0, stallCycles}, 64'd0);
      checkOutput("reset_squash_cnt", {48'd0, squashCount}, 64'd0);
      @(posedge clk);
      #1;
      rst = 1'b0;

      // Single push with execute ready: visible one cycle later, then drained
      bus.out_ready = 1'b1;
      applyStimulus(1'b1, 32'h100, 5'd0, 5'd0, 32'h0, 32'h0);
      tick();
      applyStimulus(1'b0, 32'h0, 5'd0, 5'd0, 32'h0, 32'h0);
      checkOutput("single_valid", {63'd0, bus.out_valid}, 64'd1);
      checkOutput("single_pc", {32'd0, bus.out_pc}, 64'h100);
      tick();
      checkOutput("single_drained", {63'd0, bus.out_valid}, 64'd0);

      // Fill to full, hold the third entry upstream, then drain in order across the wrap
      bus.out_ready = 1'b0;
      applyStimulus(1'b1, 32'h0, 5'd0, 5'd0, 32'h0, 32'h0);
      tick();
      applyStimulus(1'b1, 32'h4, 5'd0, 5'd0, 32'h0, 32'h0);
      tick();
      checkOutput("full_in_ready", {63'd0, bus.in_ready}, 64'd0);
      applyStimulus(1'b1, 32'h8, 5'd0, 5'd0, 32'h0, 32'h0);
      tick();
      checkOutput("full_head_pc", {32'd0, bus.out_pc}, 64'h0);
      checkOutput("full_still_blocked", {63'd0, bus.in_ready}, 64'd0);
      bus.out_ready = 1'b1;
      tick();
      checkOutput("drain_pc4", {32'd0, bus.out_pc}, 64'h4);
      checkOutput("drain_in_ready", {63'd0, bus.in_ready}, 64'd1);
      tick();
      applyStimulus(1'b0, 32'h0, 5'd0, 5'd0, 32'h0, 32'h0);
      checkOutput("drain_pc8", {32'd0, bus.out_pc}, 64'h8);
      checkOutput("drain_valid8", {63'd0, bus.out_valid}, 64'd1);
      tick();
      checkOutput("drain_empty", {63'd0, bus.out_valid}, 64'd0);

      // Write-back snoop on a buffered entry, then a write to x0 that must not patch
      bus.out_ready = 1'b0;
      applyStimulus(1'b1, 32'h20, 5'd5, 5'd3, 32'h1, 32'h2);
      tick();
      applyStimulus(1'b0, 32'h0, 5'd0, 5'd0, 32'h0, 32'h0);
      checkOutput("snoop_before", {32'd0, bus.out_read_data1}, 64'h1);
      applyWriteBack(1'b1, 5'd5, 32'hDEAD);
      tick();
      checkOutput("snoop_rs1", {32'd0, bus.out_read_data1}, 64'hDEAD);
      checkOutput("snoop_rs2_untouched", {32'd0, bus.out_read_data2}, 64'h2);
      applyWriteBack(1'b1, 5'd0, 32'hBEEF);
      tick();
      checkOutput("snoop_x0", {32'd0, bus.out_read_data1}, 64'hDEAD);

      // Write-back coinciding with the push of the entry that reads it
      applyStimulus(1'b1, 32'h24, 5'd9, 5'd7, 32'h10, 32'h11);
      applyWriteBack(1'b1, 5'd7, 32'h55);
      tick();
      applyStimulus(1'b0, 32'h0, 5'd0, 5'd0, 32'h0, 32'h0);
      applyWriteBack(1'b0, 5'd0, 32'h0);
      checkOutput("push_patch_head_rs2", {32'd0, bus.out_read_data2}, 64'h2);
      bus.out_ready = 1'b1;
      tick();
      bus.out_ready = 1'b0;
      checkOutput("push_patch_pc", {32'd0, bus.out_pc}, 64'h24);
      checkOutput("push_patch_rs2", {32'd0, bus.out_read_data2}, 64'h55);
      checkOutput("push_patch_rs1", {32'd0, bus.out_read_data1}, 64'h10);

      // Squash two buffered entries while a push is offered
      applyStimulus(1'b1, 32'h28, 5'd0, 5'd0, 32'h0, 32'h0);
      tick();
      checkOutput("pre_squash_full", {63'd0, bus.in_ready}, 64'd0);
      applyStimulus(1'b1, 32'h2C, 5'd0, 5'd0, 32'h0, 32'h0);
      bus.squash = 1'b1;
      tick();
      bus.squash = 1'b0;
      applyStimulus(1'b0, 32'h0, 5'd0, 5'd0, 32'h0, 32'h0);
      checkOutput("squash_out_valid", {63'd0, bus.out_valid}, 64'd0);
      checkOutput("squash_in_ready", {63'd0, bus.in_ready}, 64'd1);
      checkOutput("squash_count", {48'd0, squashCount}, {48'd0, expSquash1});
      tick();
      checkOutput("squash_dropped", {63'd0, bus.out_valid}, 64'd0);
      bus.squash = 1'b1;
      tick();
      bus.squash = 1'b0;
      checkOutput("squash_empty_no_count", {48'd0, squashCount}, {48'd0, expSquash1});

      // Asynchronous reset in the middle of a cycle with two entries buffered
      applyStimulus(1'b1, 32'h40, 5'd0, 5'd0, 32'h0, 32'h0);
      tick();
      applyStimulus(1'b1, 32'h44, 5'd0, 5'd0, 32'h0, 32'h0);
      tick();
      applyStimulus(1'b0, 32'h0, 5'd0, 5'd0, 32'h0, 32'h0);
      checkOutput("prereset_full", {63'd0, bus.in_ready}, 64'd0);
      #2;
      rst = 1'b1;
      #1;
      checkOutput("async_out_valid", {63'd0, bus.out_valid}, 64'd0);
      checkOutput("async_in_ready", {63'd0, bus.in_ready}, 64'd1);
      checkOutput("async_stall", {32'd0, stallCycles}, 64'd0);
      checkOutput("async_squash_cnt", {48'd0, squashCount}, 64'd0);
      @(posedge clk);
      #1;
      rst = 1'b0;
      tick();
      checkOutput("postreset_empty", {63'd0, bus.out_valid}, 64'd0);

      // Ten cycles of a valid head held by execute
      applyStimulus(1'b1, 32'h60, 5'd0, 5'd0, 32'h0, 32'h0);
      tick();
      applyStimulus(1'b0, 32'h0, 5'd0, 5'd0, 32'h0, 32'h0);
      for (int i = 0; i < 10; i++) tick();
      checkOutput("stall_10", {32'd0, stallCycles}, {32'd0, expStall10});
      bus.out_ready = 1'b1;
      tick();
      checkOutput("stall_hold", {32'd0, stallCycles}, {32'd0, expStall10});
      checkOutput("stall_drained", {63'd0, bus.out_valid}, 64'd0);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
      $finish;
   end

endmodule
